// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel: one request in flight at a time.
interface fetch_stage_if #(
  parameter int word_width = 32
);

  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [word_width-1:0] imem_addr;
  logic                  imem_resp_valid;
  logic [word_width-1:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );

endinterface

// File: rtl/fetch_slot.sv
// One-entry holding register feeding the IF/ID register; flush beats load beats drain.
module fetch_slot
  import fetch_pkg::*;
#(
  parameter int                    word_width = 32,
  parameter logic [word_width-1:0] nop_instr  = word_width'(NOP_INSTR)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  load,
  input  logic                  drain,
  input  logic [word_width-1:0] load_instr,
  input  logic [word_width-1:0] load_pc,
  output logic [word_width-1:0] instr,
  output logic [word_width-1:0] pc,
  output logic [word_width-1:0] pc_plus4,
  output logic                  valid
);

  // A bubble only replaces the instruction; the stale PCs are harmless while invalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr    <= nop_instr;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      instr <= nop_instr;
      valid <= 1'b0;
    end else if (load) begin
      instr    <= load_instr;
      pc       <= load_pc;
      pc_plus4 <= load_pc + word_width'(PC_STEP);
      valid    <= 1'b1;
    end else if (drain) begin
      instr <= nop_instr;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single outstanding imem requests,
// and handles decode stalls and Execute redirects by discarding wrong-path data.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    word_width = 32,
  parameter logic [word_width-1:0] reset_pc   = '0,
  parameter logic [word_width-1:0] nop_instr  = word_width'(NOP_INSTR)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stallF,
  input  logic                  PCSrcE,
  input  logic [word_width-1:0] PCTargetE,
  fetch_stage_if.master         imem,
  output logic [word_width-1:0] instrF,
  output logic [word_width-1:0] PCF,
  output logic [word_width-1:0] PCPlus4F,
  output logic                  fetch_valid
);

  fetch_state_t          state, state_next;
  logic [word_width-1:0] pc, pc_next;
  logic                  discard, discard_next;
  logic [word_width-1:0] target;
  logic                  slot_free;
  logic                  drain;
  logic                  load;
  logic                  target_lsb_unused;

  assign target            = {PCTargetE[word_width-1:2], 2'b00};
  assign target_lsb_unused = ^PCTargetE[1:0];
  assign slot_free         = !fetch_valid || !stallF;
  assign drain             = fetch_valid && !stallF;
  assign imem.imem_addr    = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      pc      <= reset_pc;
      discard <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      discard <= discard_next;
    end
  end

  // A redirect always wins the PC; an in-flight request it overtakes is marked for discard.
  always_comb begin
    state_next          = state;
    pc_next             = pc;
    discard_next        = discard;
    imem.imem_req_valid = 1'b0;
    load                = 1'b0;
    unique case (state)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        imem.imem_req_valid = slot_free;
        if (slot_free && imem.imem_req_ready) begin
          pc_next    = pc + word_width'(PC_STEP);
          state_next = S_WAIT;
          if (PCSrcE) discard_next = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem.imem_resp_valid) begin
          state_next   = S_REQ;
          discard_next = 1'b0;
          load         = !discard && !PCSrcE;
        end else if (PCSrcE) begin
          discard_next = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (PCSrcE) pc_next = target;
  end

  // While waiting, pc already points one word past the outstanding request.
  fetch_slot #(
    .word_width(word_width),
    .nop_instr (nop_instr)
  ) u_slot (
    .clk       (clk),
    .reset     (reset),
    .flush     (PCSrcE),
    .load      (load),
    .drain     (drain),
    .load_instr(imem.imem_resp_data),
    .load_pc   (pc - word_width'(PC_STEP)),
    .instr     (instrF),
    .pc        (PCF),
    .pc_plus4  (PCPlus4F),
    .valid     (fetch_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, reset-in-flight sequence,
// then randomized traffic against a transaction-level program-order model.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stallF = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic [31:0] instrF, PCF, PCPlus4F;
  logic        fetch_valid;

  int checks = 0;
  int failures = 0;

  fetch_stage_if #(.word_width(32)) imem_bus ();

  fetch_stage #(
    .word_width(32),
    .reset_pc  (32'h0000_0000),
    .nop_instr (NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stallF     (stallF),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem       (imem_bus),
    .instrF     (instrF),
    .PCF        (PCF),
    .PCPlus4F   (PCPlus4F),
    .fetch_valid(fetch_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        pcsrc;
    logic [31:0] tgt;
    logic        ready;
    logic        resp;
    logic [31:0] resp_addr;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_fv;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5EED_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic stall, input logic pcsrc, input logic [31:0] tgt,
                               input logic ready, input logic resp, input logic [31:0] data);
    @(negedge clk);
    stallF                   = stall;
    PCSrcE                   = pcsrc;
    PCTargetE                = tgt;
    imem_bus.imem_req_ready  = ready;
    imem_bus.imem_resp_valid = resp;
    imem_bus.imem_resp_data  = data;
    #1;
  endtask

  task automatic addVec(input logic stall, input logic pcsrc, input logic [31:0] tgt, input logic ready,
                        input logic resp, input logic [31:0] raddr, input logic exp_req,
                        input logic [31:0] exp_addr, input logic exp_fv, input logic [31:0] exp_pc);
    vec_t v;
    v.stall = stall; v.pcsrc = pcsrc; v.tgt = tgt; v.ready = ready; v.resp = resp;
    v.resp_addr = raddr; v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_fv = exp_fv; v.exp_pc = exp_pc;
    vecs.push_back(v);
  endtask

  logic        busy, accept, prev_hold, prev_redirect;
  logic [31:0] mem_addr, exp_req, exp_deliver, hold_pc, hold_instr, hold_pc4;
  int          lat, consumed;

  initial begin
    imem_bus.imem_req_ready  = 1'b0;
    imem_bus.imem_resp_valid = 1'b0;
    imem_bus.imem_resp_data  = '0;

    // cycle-by-cycle walk of fetch, stall, redirects, alignment and PC wrap
    addVec(0,0,0,1,0,0,            0,0,0,0);
    addVec(0,0,0,1,0,0,            1,32'h0,0,0);
    addVec(0,0,0,1,1,32'h0,        0,0,0,0);
    addVec(0,0,0,1,0,0,            1,32'h4,1,32'h0);
    addVec(0,0,0,1,1,32'h4,        0,0,0,0);
    for (int i = 0; i < 5; i++) addVec(1,0,0,1,0,0, 0,0,1,32'h4);
    addVec(0,0,0,1,0,0,            1,32'h8,1,32'h4);
    addVec(0,1,32'h100,1,0,0,      0,0,0,0);
    addVec(0,0,0,1,1,32'h8,        0,0,0,0);
    addVec(0,0,0,1,0,0,            1,32'h100,0,0);
    addVec(0,1,32'h200,1,1,32'h100,0,0,0,0);
    addVec(0,1,32'h303,1,0,0,      1,32'h200,0,0);
    addVec(0,0,0,1,1,32'h200,      0,0,0,0);
    addVec(0,0,0,1,0,0,            1,32'h300,0,0);
    addVec(0,0,0,1,1,32'h300,      0,0,0,0);
    addVec(1,1,32'hFFFF_FFFF,1,0,0,0,0,1,32'h300);
    addVec(0,0,0,1,0,0,            1,32'hFFFF_FFFC,0,0);
    addVec(0,0,0,1,1,32'hFFFF_FFFC,0,0,0,0);
    addVec(0,0,0,1,0,0,            1,32'h0,1,32'hFFFF_FFFC);
    addVec(0,0,0,1,0,0,            0,0,0,0);
    addVec(0,0,0,1,1,32'h0,        0,0,0,0);
    addVec(0,0,0,0,0,0,            1,32'h4,1,32'h0);
    addVec(0,0,0,1,0,0,            1,32'h4,0,0);

    repeat (2) @(negedge clk);
    checkOutput("reset req_valid", imem_bus.imem_req_valid, 0);
    checkOutput("reset fetch_valid", fetch_valid, 0);
    checkOutput("reset instrF", instrF, NOP);
    checkOutput("reset PCF", PCF, 0);
    checkOutput("reset PCPlus4F", PCPlus4F, 0);
    @(posedge clk);
    #2 reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].stall, vecs[i].pcsrc, vecs[i].tgt, vecs[i].ready, vecs[i].resp,
                    mem_fn(vecs[i].resp_addr));
      checkOutput($sformatf("vec%0d req_valid", i), imem_bus.imem_req_valid, vecs[i].exp_req);
      if (vecs[i].exp_req) checkOutput($sformatf("vec%0d addr", i), imem_bus.imem_addr, vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d fetch_valid", i), fetch_valid, vecs[i].exp_fv);
      checkOutput($sformatf("vec%0d instrF", i), instrF, vecs[i].exp_fv ? mem_fn(vecs[i].exp_pc) : NOP);
      if (vecs[i].exp_fv) begin
        checkOutput($sformatf("vec%0d PCF", i), PCF, vecs[i].exp_pc);
        checkOutput($sformatf("vec%0d PCPlus4F", i), PCPlus4F, vecs[i].exp_pc + 32'd4);
      end
    end

    // reset lands while the request for 0x4 is outstanding
    @(negedge clk);
    imem_bus.imem_req_ready = 1'b1;
    imem_bus.imem_resp_valid = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("midreset req_valid", imem_bus.imem_req_valid, 0);
    checkOutput("midreset fetch_valid", fetch_valid, 0);
    checkOutput("midreset instrF", instrF, NOP);
    checkOutput("midreset PCF", PCF, 0);
    checkOutput("midreset PCPlus4F", PCPlus4F, 0);
    applyStimulus(0,0,0,1,1,mem_fn(32'h4));
    reset = 1'b1;
    checkOutput("restart idle req_valid", imem_bus.imem_req_valid, 0);
    applyStimulus(0,0,0,0,1,mem_fn(32'h4));
    checkOutput("restart late resp fetch_valid", fetch_valid, 0);
    checkOutput("restart req_valid", imem_bus.imem_req_valid, 1);
    checkOutput("restart addr", imem_bus.imem_addr, 32'h0);
    applyStimulus(0,0,0,1,0,0);
    checkOutput("restart late resp ignored", fetch_valid, 0);
    checkOutput("restart accept addr", imem_bus.imem_addr, 32'h0);
    applyStimulus(0,0,0,1,1,mem_fn(32'h0));
    applyStimulus(0,0,0,0,0,0);
    checkOutput("restart fetch_valid", fetch_valid, 1);
    checkOutput("restart PCF", PCF, 32'h0);
    checkOutput("restart instrF", instrF, mem_fn(32'h0));

    // randomized traffic: delivered stream must follow program order from reset/redirect targets
    @(negedge clk);
    reset = 1'b0;
    stallF = 0; PCSrcE = 0; imem_bus.imem_resp_valid = 0;
    @(negedge clk);
    reset = 1'b1;
    busy = 0; lat = 0; mem_addr = '0; exp_req = 32'h0; exp_deliver = 32'h0;
    prev_hold = 0; prev_redirect = 0; hold_pc = '0; hold_instr = '0; hold_pc4 = '0; consumed = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (busy && lat == 0) begin
        imem_bus.imem_resp_valid = 1'b1;
        imem_bus.imem_resp_data  = mem_fn(mem_addr);
      end else begin
        imem_bus.imem_resp_valid = 1'b0;
        imem_bus.imem_resp_data  = $urandom;
      end
      stallF = ($urandom_range(0, 3) == 0);
      PCSrcE = ($urandom_range(0, 11) == 0);
      PCTargetE = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 1023));
      imem_bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (prev_redirect) begin
        checkOutput("rand bubble fetch_valid", fetch_valid, 0);
        checkOutput("rand bubble instrF", instrF, NOP);
      end
      if (prev_hold) begin
        checkOutput("rand stall fetch_valid", fetch_valid, 1);
        checkOutput("rand stall PCF", PCF, hold_pc);
        checkOutput("rand stall PCPlus4F", PCPlus4F, hold_pc4);
        checkOutput("rand stall instrF", instrF, hold_instr);
      end
      if (busy) checkOutput("rand single outstanding", imem_bus.imem_req_valid, 0);
      if (fetch_valid && stallF) checkOutput("rand backpressure", imem_bus.imem_req_valid, 0);
      if (fetch_valid && !stallF && !PCSrcE) begin
        checkOutput("rand deliver PCF", PCF, exp_deliver);
        checkOutput("rand deliver PCPlus4F", PCPlus4F, exp_deliver + 32'd4);
        checkOutput("rand deliver instrF", instrF, mem_fn(exp_deliver));
        exp_deliver = exp_deliver + 32'd4;
        consumed++;
      end
      accept = imem_bus.imem_req_valid && imem_bus.imem_req_ready;
      if (accept) checkOutput("rand request addr", imem_bus.imem_addr, exp_req);
      prev_hold     = fetch_valid && stallF && !PCSrcE;
      hold_pc       = PCF;
      hold_pc4      = PCPlus4F;
      hold_instr    = instrF;
      prev_redirect = PCSrcE;
      if (imem_bus.imem_resp_valid) busy = 0;
      else if (busy) lat--;
      if (accept) begin
        busy = 1;
        mem_addr = imem_bus.imem_addr;
        lat = $urandom_range(0, 2);
      end
      if (PCSrcE) begin
        exp_req     = PCTargetE & 32'hFFFF_FFFC;
        exp_deliver = PCTargetE & 32'hFFFF_FFFC;
      end else if (accept) begin
        exp_req = exp_req + 32'd4;
      end
    end
    checks++;
    if (consumed < 50) begin
      failures++;
      $display("[TB] FAIL rand progress: actual=%0d delivered required>=50", consumed);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
